shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Command-driven controller directly upstream of the 4-bit universal shift register. It accepts LOAD / shift-right-N / shift-left-N commands over a valid/ready handshake. It drives the register's mode selects, parallel data and serial fill inputs cycle by cycle, feeding the register's parallel output back so that shifts accumulate. When a command finishes it pulses done and presents the resulting register value.

Parameters:
WIDTH, 4, register width; must match the downstream shift register.
CNT_W, 3, width of the shift-count field; up to 2^CNT_W-1 shifts per command.

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk)
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  0=NOP, 1=LOAD, 2=SHR, 3=SHL
cmd_data  input  WIDTH  parallel value for LOAD
cmd_count  input  CNT_W  number of single-bit shifts for SHR/SHL
cmd_fill  input  1  serial fill bit used for every shift step of the command
sr_q  input  WIDTH  parallel output of downstream register (feedback)
sr_s1  output  1  register mode select high bit
sr_s0  output  1  register mode select low bit
sr_data_in  output  WIDTH  register parallel input
sr_msb_in  output  1  register serial input, right-shift path
sr_lsb_in  output  1  register serial input, left-shift path
busy  output  1  command in progress
done  output  1  one-cycle completion pulse
result  output  WIDTH  register value captured at completion, held until next done

Behaviour:
- Mode encoding on {sr_s1,sr_s0}: 00 = parallel load; 01 = right shift, sr_msb_in enters the MSB; 10 = left shift, sr_lsb_in enters the LSB. 11 is never driven.
- The downstream register always updates from sr_data_in, so in every non-shift cycle the sequencer holds the value by driving mode 00 with sr_data_in = sr_q. In shift cycles it drives sr_data_in = sr_q.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, busy=0. A command is accepted when cmd_valid && cmd_ready. It is captured in that cycle; op, data, count and fill are registered. Next state:
  - LOAD op -> LOAD.
  - SHR/SHL with count>0 -> SHIFT.
  - NOP, or SHR/SHL with count=0 -> DONE.
- LOAD (1 cycle): mode 00, sr_data_in = captured data -> DONE.
- SHIFT: mode 01 (SHR) or 10 (SHL). Captured fill bit is driven on both sr_msb_in and sr_lsb_in. The remaining count decrements each cycle; after exactly N SHIFT cycles -> DONE.
- DONE (1 cycle): done=1, result <= sr_q (already reflects the last update), hold mode -> IDLE.
- busy=1 in LOAD, SHIFT and DONE; cmd_ready=0 in those states.
- Latency from accept cycle T: LOAD done at T+2; shift-N done at T+N+1; NOP/count-0 done at T+1.
- Back-to-back: a new command can be accepted in the IDLE cycle following DONE. There is no accept during DONE.
- cmd_* inputs are ignored while cmd_ready=0.
- Reset (rst=0 at an edge), including mid-command: state -> IDLE, count -> 0, done=0, busy=0, result=0, drive hold mode. The aborted command produces no done pulse. cmd_ready is 0 while rst=0 and 1 in the first cycle after release.
- Serial inputs are driven 0 when not in SHIFT.

Decomposition:
- Shared package: op codes (OP_NOP, OP_LOAD, OP_SHR, OP_SHL), state enum, mode encodings (MODE_LOAD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10).
- One natural sub-module: shift_step_counter. It is a loadable CNT_W down-counter with a zero flag, used for SHIFT termination.

Test Plan:
- Reset held 3 cycles then released -> cmd_ready=0 during reset, 1 after; busy=0, done=0, result=0, {s1,s0}=00.
- LOAD cmd_data=4'b1011 accepted at T -> mode 00 with data 1011 at T+1; done=1 at T+2; result=1011.
- From 1011: SHR count=2 fill=0 -> mode 01 for 2 cycles; register 0101 then 0010; done at T+3; result=0010.
- From 0010: SHL count=3 fill=1 -> 0101, 1011, 0111; done at T+4; result=0111.
- SHR count=0 from 0111 -> done at T+1, result=0111, no mode 01 cycle; hold new cmd_valid during busy -> accepted only in IDLE.
- rst=0 asserted in the 2nd cycle of a SHL count=5 -> next cycle IDLE, no done pulse, mode 00; result retains its reset value 0.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: command op codes, FSM states
// and the {s1,s0} mode encodings of the downstream universal shift register.
package shift_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_LOAD = 2'd1,
    OP_SHR  = 2'd2,
    OP_SHL  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_LOAD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;

  // Only shift ops reach this; anything that is not SHL is treated as SHR.
  function automatic logic [1:0] shift_mode(input op_e op);
    return (op == OP_SHL) ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/shift_sequencer_if.sv
// Command handshake, register drive/feedback and status bundle of the sequencer.
// slave = sequencer side, master = command source plus downstream register.
interface shift_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;

  logic [WIDTH-1:0] sr_q;
  logic             sr_s1;
  logic             sr_s0;
  logic [WIDTH-1:0] sr_data_in;
  logic             sr_msb_in;
  logic             sr_lsb_in;

  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, sr_q,
    output cmd_ready, sr_s1, sr_s0, sr_data_in, sr_msb_in, sr_lsb_in,
    output busy, done, result
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_count, cmd_fill, sr_q,
    input  cmd_ready, sr_s1, sr_s0, sr_data_in, sr_msb_in, sr_lsb_in,
    input  busy, done, result
  );

endinterface

// File: rtl/shift_step_counter.sv
// Loadable down-counter with zero flag; counts remaining shift steps.
// Saturates at zero, so an extra decrement is harmless.
module shift_step_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/shift_sequencer.sv
// Command sequencer for a universal shift register: LOAD done 2 cycles after accept,
// shift-N after N+1, NOP/count-0 after 1. Accepts only in IDLE (cmd_ready low while busy).
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  shift_sequencer_if.slave  bus
);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [WIDTH-1:0] data_q;
  logic             fill_q;
  logic [WIDTH-1:0] result_q;

  logic             accept;
  logic             cnt_zero;
  logic [1:0]       mode;
  logic             cmd_ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sr_data_in;
  logic             serial_in;

  assign accept = bus.cmd_valid && cmd_ready;

  // Counter holds N-1 on entry to SHIFT so the zero flag marks the last step.
  shift_step_counter #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept),
    .load_val_i (bus.cmd_count - CNT_W'(1)),
    .dec_i      (state_q == ST_SHIFT),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(bus.cmd_op))
            OP_LOAD:        state_d = ST_LOAD;
            OP_SHR, OP_SHL: state_d = (bus.cmd_count != '0) ? ST_SHIFT : ST_DONE;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_LOAD:  state_d = ST_DONE;
      ST_SHIFT: if (cnt_zero) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // While rst is low the register is parked in hold mode regardless of state.
  always_comb begin
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mode       = MODE_LOAD;
    sr_data_in = bus.sr_q;
    serial_in  = 1'b0;
    if (rst) begin
      case (state_q)
        ST_IDLE: cmd_ready = 1'b1;
        ST_LOAD: begin
          busy       = 1'b1;
          sr_data_in = data_q;
        end
        ST_SHIFT: begin
          busy      = 1'b1;
          mode      = shift_mode(op_q);
          serial_in = fill_q;
        end
        ST_DONE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      op_q   <= OP_NOP;
      data_q <= '0;
      fill_q <= 1'b0;
    end else if (accept) begin
      op_q   <= op_e'(bus.cmd_op);
      data_q <= bus.cmd_data;
      fill_q <= bus.cmd_fill;
    end
  end

  // In DONE the register already holds the final value of the command.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q <= '0;
    end else if (state_q == ST_DONE) begin
      result_q <= bus.sr_q;
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.result     = result_q;
  assign bus.sr_s1      = mode[1];
  assign bus.sr_s0      = mode[0];
  assign bus.sr_data_in = sr_data_in;
  assign bus.sr_msb_in  = serial_in;
  assign bus.sr_lsb_in  = serial_in;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench: drives commands, models the downstream 4-bit universal shift
// register, and checks handshake, mode, latency and result against hand values.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sreg = 4'b0000;
  int         checks = 0;
  int         errors = 0;

  shift_sequencer_if #(.WIDTH(4), .CNT_W(3)) bus ();

  shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register.
  assign bus.sr_q = sreg;
  always @(posedge clk) begin
    case ({bus.sr_s1, bus.sr_s0})
      2'b00:   sreg <= bus.sr_data_in;
      2'b01:   sreg <= {bus.sr_msb_in, bus.sr_data_in[3:1]};
      2'b10:   sreg <= {bus.sr_data_in[2:0], bus.sr_lsb_in};
      default: sreg <= 4'bxxxx;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input string nm, input logic [1:0] op, input logic [3:0] d,
                        input logic [2:0] c, input logic f, input int exp_lat,
                        input logic [1:0] exp_mode, input logic [3:0] exp_res);
    int n;
    chk({nm, "_rdy"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.cmd_count = c;
    bus.cmd_fill  = f;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n <= 20) begin
      chk({nm, "_mode"}, 32'({bus.sr_s1, bus.sr_s0}), 32'(exp_mode));
      chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
      if (op == 2'd1) chk({nm, "_din"}, 32'(bus.sr_data_in), 32'(d));
      if (op >= 2'd2) chk({nm, "_fill"}, 32'({bus.sr_msb_in, bus.sr_lsb_in}), 32'({f, f}));
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(exp_lat));
    chk({nm, "_srq"}, 32'(bus.sr_q), 32'(exp_res));
    @(negedge clk);
    chk({nm, "_res"}, 32'(bus.result), 32'(exp_res));
    chk({nm, "_done0"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int pulses;
    rst           = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 4'd0;
    bus.cmd_count = 3'd0;
    bus.cmd_fill  = 1'b0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rdy", 32'(bus.cmd_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rdy", 32'(bus.cmd_ready), 32'd1);
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_res", 32'(bus.result), 32'd0);
    chk("post_mode", 32'({bus.sr_s1, bus.sr_s0}), 32'd0);

    do_cmd("load", 2'd1, 4'b1011, 3'd0, 1'b0, 2, 2'b00, 4'b1011);
    do_cmd("shr2", 2'd2, 4'b0000, 3'd2, 1'b0, 3, 2'b01, 4'b0010);
    do_cmd("shl3", 2'd3, 4'b0000, 3'd3, 1'b1, 4, 2'b10, 4'b0111);

    // SHR count 0, with the next command held valid through DONE.
    bus.cmd_op    = 2'd2;
    bus.cmd_count = 3'd0;
    bus.cmd_fill  = 1'b1;
    bus.cmd_valid = 1'b1;
    chk("shr0_rdy", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_op    = 2'd1;
    bus.cmd_data  = 4'b0110;
    chk("shr0_done", 32'(bus.done), 32'd1);
    chk("shr0_mode", 32'({bus.sr_s1, bus.sr_s0}), 32'd0);
    chk("shr0_nordy", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk("shr0_res", 32'(bus.result), 32'b0111);
    chk("b2b_idle", 32'(bus.busy), 32'd0);
    chk("b2b_rdy", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 32'd1);
    chk("b2b_din", 32'(bus.sr_data_in), 32'b0110);
    @(negedge clk);
    chk("b2b_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    chk("b2b_res", 32'(bus.result), 32'b0110);

    // Reset during the second SHIFT cycle of SHL count 5.
    bus.cmd_op    = 2'd3;
    bus.cmd_count = 3'd5;
    bus.cmd_fill  = 1'b0;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("abort_mode", 32'({bus.sr_s1, bus.sr_s0}), 32'b10);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_hold", 32'({bus.sr_s1, bus.sr_s0}), 32'd0);
    @(negedge clk);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_rdy", 32'(bus.cmd_ready), 32'd0);
    chk("abort_res", 32'(bus.result), 32'd0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_nodone", 32'(pulses), 32'd0);
    chk("abort_srq", 32'(bus.sr_q), 32'b1100);
    chk("abort_res2", 32'(bus.result), 32'd0);

    do_cmd("nop", 2'd0, 4'b0000, 3'd0, 1'b0, 1, 2'b00, 4'b1100);
    do_cmd("shr7", 2'd2, 4'b0000, 3'd7, 1'b1, 8, 2'b01, 4'b1111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
